sequenciador_programa: RTL and testbench

SEQUENCIADOR_PROGRAMA -- requirements
Module: sequenciador_programa

---
 rtl/sequenciador_programa_pkg.sv | 23 ++
 rtl/sequenciador_programa_memoria.sv | 29 ++
 rtl/sequenciador_programa.sv | 168 ++++++++++++++++
 tb/tb_sequenciador_programa.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequenciador_programa_pkg.sv
// Shared definitions for the program sequencer: opcodes, FSM encoding and
// default sizing.
package sequenciador_programa_pkg;

  localparam int DEPTH_DEFAULT   = 32;
  localparam int TIMEOUT_DEFAULT = 15;

  localparam logic [2:0] OP_MVI = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_IMM   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_END   = 3'd4
  } state_t;

  // mvi is the only two-word instruction; opcode lives in DIN[8:6]
  function automatic logic is_mvi(input logic [2:0] opcode);
    return (opcode == OP_MVI);
  endfunction

endpackage

// File: rtl/sequenciador_programa_memoria.sv
// Program storage: one synchronous write port, two combinational read ports
// (current word and the word after it). Contents survive reset.
module memoria_programa #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [15:0]   rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [15:0]   rdata_b
);

  logic [15:0] mem_q [DEPTH];

  // Write port; deliberately no reset so a program outlives Reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/sequenciador_programa.sv
// Program sequencer: streams a stored program word by word to a processor,
// waiting for Done after every instruction and flagging timeouts/bad programs.
module sequenciador_programa
  import sequenciador_programa_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Prog_we,
  input  logic [AW-1:0] Prog_addr,
  input  logic [15:0]   Prog_data,
  input  logic [LW-1:0] Prog_len,
  input  logic          Done,
  output logic [15:0]   DIN,
  output logic          Run,
  output logic          Busy,
  output logic          Finished,
  output logic          Err,
  output logic [LW-1:0] Instr_count
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [LW-1:0] pc_q, pc_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] count_q, count_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   din_q, din_d;
  logic          run_q, run_d;
  logic          busy_q, busy_d;
  logic          fin_q, fin_d;
  logic          err_q, err_d;

  logic [15:0]   word_pc_s, word_pc1_s;
  logic [LW-1:0] len_clamp_s, pc_next_s;
  logic [AW-1:0] addr_pc1_s;
  logic          mem_we_s, issue_mvi_s;

  assign mem_we_s    = Prog_we & (state_q == ST_IDLE) & ~Reset;
  assign addr_pc1_s  = pc_q[AW-1:0] + AW'(1);
  assign len_clamp_s = (Prog_len > LW'(DEPTH)) ? LW'(DEPTH) : Prog_len;
  assign pc_next_s   = pc_q + ((state_q == ST_IMM) ? LW'(2) : LW'(1));
  assign issue_mvi_s = is_mvi(word_pc_s[8:6]);

  memoria_programa #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (Clock),
    .we      (mem_we_s),
    .waddr   (Prog_addr),
    .wdata   (Prog_data),
    .raddr_a (pc_q[AW-1:0]),
    .rdata_a (word_pc_s),
    .raddr_b (addr_pc1_s),
    .rdata_b (word_pc1_s)
  );

  // Next-state and next-output computation
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    count_d = count_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    run_d   = 1'b0;
    fin_d   = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          pc_d    = '0;
          len_d   = len_clamp_s;
          count_d = '0;
          err_d   = 1'b0;
          if (len_clamp_s == '0) begin
            state_d = ST_END;
            fin_d   = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // An mvi whose immediate would fall past the program end is rejected unissued
        if (issue_mvi_s && ((pc_q + LW'(1)) >= len_q)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          run_d   = 1'b1;
          din_d   = word_pc_s;
          cnt_d   = '0;
          state_d = issue_mvi_s ? ST_IMM : ST_WAIT;
        end
      end
      ST_WAIT, ST_IMM: begin
        din_d = (state_q == ST_IMM) ? word_pc1_s : word_pc_s;
        if (Done) begin
          pc_d    = pc_next_s;
          count_d = count_q + LW'(1);
          cnt_d   = '0;
          if (pc_next_s < len_q) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_END;
            fin_d   = 1'b1;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      count_q <= '0;
      cnt_q   <= '0;
      din_q   <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      err_q   <= err_d;
    end
  end

  assign DIN         = din_q;
  assign Run         = run_q;
  assign Busy        = busy_q;
  assign Finished    = fin_q;
  assign Err         = err_q;
  assign Instr_count = count_q;

endmodule

// File: tb/tb_sequenciador_programa.sv
// Scoreboard bench for sequenciador_programa: a program-level reference model
// predicts issued words and run outcomes; a monitor checks them as they appear.
module tb_sequenciador_programa;

  localparam int DEPTH = 32;
  localparam int TMO   = 15;
  localparam int NEVER = 999;

  localparam int K_ISSUE = 0;
  localparam int K_END   = 1;
  localparam int K_ERR   = 2;

  logic        Clock = 1'b0;
  logic        Reset, Start, Prog_we, Done;
  logic [4:0]  Prog_addr;
  logic [15:0] Prog_data;
  logic [5:0]  Prog_len;
  logic [15:0] DIN;
  logic        Run, Busy, Finished, Err;
  logic [5:0]  Instr_count;

  typedef struct {
    int          kind;
    logic [15:0] word;
    logic [15:0] held;
    int          count;
  } exp_t;

  exp_t        exp_q[$];
  int          delay_q[$];
  logic [15:0] tb_mem[DEPTH];
  int          delays[DEPTH];
  int          total = 0;
  int          bad   = 0;
  bit          mon_en = 1'b0;
  bit          abort_expected = 1'b0;

  always #5 Clock = ~Clock;

  sequenciador_programa dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .Prog_we     (Prog_we),
    .Prog_addr   (Prog_addr),
    .Prog_data   (Prog_data),
    .Prog_len    (Prog_len),
    .Done        (Done),
    .DIN         (DIN),
    .Run         (Run),
    .Busy        (Busy),
    .Finished    (Finished),
    .Err         (Err),
    .Instr_count (Instr_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input int kind, input logic [15:0] word,
                              input logic [15:0] held, input int count);
    exp_t e;
    e.kind  = kind;
    e.word  = word;
    e.held  = held;
    e.count = count;
    return e;
  endfunction

  // Reference model: walk the program as a processor would see it
  task automatic model_run(input int plen);
    int          len;
    int          pc;
    int          n;
    logic [15:0] w;
    bit          mvi;
    len = (plen > DEPTH) ? DEPTH : plen;
    pc  = 0;
    n   = 0;
    while (1) begin
      if (pc >= len) begin
        exp_q.push_back(mk(K_END, 16'h0, 16'h0, n));
        break;
      end
      w   = tb_mem[pc];
      mvi = (w[8:6] == 3'b001);
      if (mvi && (pc + 1 >= len)) begin
        exp_q.push_back(mk(K_ERR, 16'h0, 16'h0, n));
        break;
      end
      exp_q.push_back(mk(K_ISSUE, w, mvi ? tb_mem[pc + 1] : w, 0));
      delay_q.push_back(delays[n]);
      if (delays[n] >= TMO) begin
        exp_q.push_back(mk(K_ERR, 16'h0, 16'h0, n));
        break;
      end
      pc += mvi ? 2 : 1;
      n++;
    end
  endtask

  task automatic write_word(input int addr, input logic [15:0] data);
    Prog_we   = 1'b1;
    Prog_addr = 5'(addr);
    Prog_data = data;
    @(negedge Clock);
    Prog_we = 1'b0;
    tb_mem[addr] = data;
  endtask

  task automatic pulse_start(input int len);
    Prog_len = 6'(len);
    Start    = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1500; i++) begin
      if (exp_q.size() == 0 && Busy === 1'b0) break;
      @(negedge Clock);
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    delay_q.delete();
    repeat (25) @(negedge Clock);
  endtask

  task automatic run_prog(input int len);
    model_run(len);
    pulse_start(len);
    wait_done();
  endtask

  task automatic set_delays(input int d);
    for (int k = 0; k < DEPTH; k++) delays[k] = d;
  endtask

  // Processor stand-in: answers each Run with Done after a scheduled delay
  initial begin
    int d;
    Done = 1'b0;
    forever begin
      @(negedge Clock);
      if (Run === 1'b1) begin
        d = (delay_q.size() > 0) ? delay_q.pop_front() : NEVER;
        if (d < 40) begin
          repeat (d) @(negedge Clock);
          Done = 1'b1;
          @(negedge Clock);
          Done = 1'b0;
        end
      end else if (mon_en && Busy === 1'b0 && $urandom_range(0, 3) == 0) begin
        Done = 1'b1;
        @(negedge Clock);
        Done = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents Run or an outcome
  initial begin
    bit          prev_busy;
    bit          saw_fin;
    bit          held_valid;
    logic [15:0] cur_held;
    exp_t        e;
    prev_busy  = 1'b0;
    saw_fin    = 1'b0;
    held_valid = 1'b0;
    cur_held   = 16'h0;
    wait (mon_en);
    forever begin
      @(negedge Clock);
      if (abort_expected) held_valid = 1'b0;
      if (Busy === 1'b1 && !prev_busy) saw_fin = 1'b0;
      if (Run === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_run: DIN=%h, no issue expected", DIN);
        end else begin
          e = exp_q.pop_front();
          check("run_kind", 32'(e.kind), 32'(K_ISSUE));
          check("run_din", 32'(DIN), 32'(e.word));
          cur_held   = e.held;
          held_valid = 1'b1;
        end
      end else if (held_valid) begin
        check("held_din", 32'(DIN), 32'(cur_held));
      end
      if (Finished === 1'b1) begin
        saw_fin = 1'b1;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_finish: count=%0d, no finish expected", Instr_count);
        end else begin
          e = exp_q.pop_front();
          check("finish_kind", 32'(e.kind), 32'(K_END));
          check("finish_count", 32'(Instr_count), 32'(e.count));
          check("finish_err", 32'(Err), 32'd0);
          check("finish_busy", 32'(Busy), 32'd1);
        end
      end
      if (prev_busy && Busy !== 1'b1 && !saw_fin && !abort_expected) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_abort: Err=%0d, no error expected", Err);
        end else begin
          e = exp_q.pop_front();
          check("error_kind", 32'(e.kind), 32'(K_ERR));
          check("error_flag", 32'(Err), 32'd1);
          check("error_count", 32'(Instr_count), 32'(e.count));
        end
      end
      prev_busy = (Busy === 1'b1);
    end
  end

  // Stimulus: directed scenarios followed by randomized programs
  initial begin
    logic [15:0] w;
    int          nw;
    int          r;
    Reset     = 1'b1;
    Start     = 1'b0;
    Prog_we   = 1'b0;
    Prog_addr = 5'd0;
    Prog_data = 16'h0;
    Prog_len  = 6'd0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    check("rst_din", 32'(DIN), 32'd0);
    check("rst_run", 32'(Run), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_finished", 32'(Finished), 32'd0);
    check("rst_err", 32'(Err), 32'd0);
    check("rst_count", 32'(Instr_count), 32'd0);
    for (int k = 0; k < DEPTH; k++) write_word(k, 16'($urandom));
    mon_en = 1'b1;

    // mvi R0,#5 ; mv R0,R1
    write_word(0, 16'h0040);
    write_word(1, 16'h0005);
    write_word(2, 16'h0001);
    set_delays(3);
    run_prog(3);
    check("basic_count", 32'(Instr_count), 32'd2);

    // empty program
    model_run(0);
    pulse_start(0);
    check("empty_busy", 32'(Busy), 32'd1);
    check("empty_finished", 32'(Finished), 32'd1);
    check("empty_run", 32'(Run), 32'd0);
    @(negedge Clock);
    check("empty_busy_drop", 32'(Busy), 32'd0);
    wait_done();

    // single instruction never acknowledged
    write_word(0, 16'h0001);
    set_delays(NEVER);
    run_prog(1);
    check("timeout_err", 32'(Err), 32'd1);
    check("timeout_busy", 32'(Busy), 32'd0);

    // mvi with no room for its immediate
    write_word(0, 16'h0040);
    run_prog(1);
    check("trunc_err", 32'(Err), 32'd1);

    // reset while waiting for Done
    write_word(0, 16'h0001);
    write_word(1, 16'h0002);
    write_word(2, 16'h0003);
    set_delays(NEVER);
    model_run(3);
    pulse_start(3);
    for (int i = 0; i < 20; i++) begin
      if (Run === 1'b1) break;
      @(negedge Clock);
    end
    repeat (3) @(negedge Clock);
    abort_expected = 1'b1;
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("abort_din", 32'(DIN), 32'd0);
    check("abort_run", 32'(Run), 32'd0);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_finished", 32'(Finished), 32'd0);
    check("abort_err", 32'(Err), 32'd0);
    check("abort_count", 32'(Instr_count), 32'd0);
    exp_q.delete();
    delay_q.delete();
    repeat (3) @(negedge Clock);
    abort_expected = 1'b0;
    set_delays(2);
    run_prog(3);

    // Start and Prog_we while busy are ignored
    write_word(0, 16'h0040);
    write_word(1, 16'h0005);
    write_word(2, 16'h0001);
    set_delays(3);
    model_run(3);
    pulse_start(3);
    repeat (2) @(negedge Clock);
    Start     = 1'b1;
    Prog_we   = 1'b1;
    Prog_addr = 5'd0;
    Prog_data = 16'hFFFF;
    @(negedge Clock);
    Start   = 1'b0;
    Prog_we = 1'b0;
    wait_done();
    run_prog(3);

    // randomized programs, lengths and Done latencies
    for (int it = 0; it < 25; it++) begin
      nw = $urandom_range(0, 12);
      for (int k = 0; k < nw; k++) begin
        w = 16'($urandom);
        if ($urandom_range(0, 9) < 3) w[8:6] = 3'b001;
        write_word($urandom_range(0, DEPTH - 1), w);
      end
      for (int k = 0; k < DEPTH; k++) begin
        r = $urandom_range(0, 99);
        if (r < 80)      delays[k] = $urandom_range(0, 5);
        else if (r < 88) delays[k] = TMO - 1;
        else if (r < 94) delays[k] = TMO;
        else             delays[k] = 20;
      end
      run_prog($urandom_range(0, 40));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
